// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: issues req/ack instruction fetches,
// selects the next PC (PC+4 / branch / jump / jr) and holds redirects that arrive between updates.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        fetch_ack,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [1:0]  pc_source,
  output logic        pc_update,
  output logic        flush
);

  localparam int unsigned AW = 32;
  localparam int unsigned SW = 2;
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);
  localparam logic [SW-1:0] SRC_SEQ    = 2'b00;
  localparam logic [SW-1:0] SRC_BRANCH = 2'b01;
  localparam logic [SW-1:0] SRC_JUMP   = 2'b10;
  localparam logic [SW-1:0] SRC_JR     = 2'b11;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            pend_valid;
  logic [SW-1:0]   pend_src;
  logic [AW-1:0]   pend_target;

  logic            do_update;
  logic            live_valid;
  logic [SW-1:0]   live_src;
  logic [AW-1:0]   live_target;
  logic [AW-1:0]   pc_nxt;
  logic [SW-1:0]   src_nxt;
  logic            pend_valid_nxt;
  logic [SW-1:0]   pend_src_nxt;
  logic [AW-1:0]   pend_target_nxt;
  logic            fetch_req_nxt;

  assign pc_plus4   = pc + AW'(4);
  assign fetch_addr = pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = REQ;
      REQ:  if (fetch_ack && stall) state_nxt = HOLD;
      HOLD: if (!stall) state_nxt = REQ;
      default: state_nxt = BOOT;
    endcase
  end

  // Update decision, redirect priority and pending-entry bookkeeping
  always_comb begin
    do_update       = 1'b0;
    live_valid      = 1'b0;
    live_src        = SRC_SEQ;
    live_target     = '0;
    pc_nxt          = pc_plus4;
    src_nxt         = SRC_SEQ;
    pend_valid_nxt  = pend_valid;
    pend_src_nxt    = pend_src;
    pend_target_nxt = pend_target;
    fetch_req_nxt   = (state_nxt == REQ);

    case (state)
      REQ:     do_update = fetch_ack && !stall;
      HOLD:    do_update = !stall;
      default: do_update = 1'b0;
    endcase

    if (jr) begin
      live_valid  = 1'b1;
      live_src    = SRC_JR;
      live_target = jr_target;
    end else if (jump) begin
      live_valid  = 1'b1;
      live_src    = SRC_JUMP;
      live_target = jump_target;
    end else if (branch_taken) begin
      live_valid  = 1'b1;
      live_src    = SRC_BRANCH;
      live_target = branch_target;
    end

    if (live_valid) begin
      pc_nxt  = live_target & ADDR_MASK;
      src_nxt = live_src;
    end else if (pend_valid) begin
      pc_nxt  = pend_target & ADDR_MASK;
      src_nxt = pend_src;
    end

    // A redirect seen on a non-update cycle is kept; the newest one wins
    if (do_update) begin
      pend_valid_nxt = 1'b0;
    end else if (live_valid) begin
      pend_valid_nxt  = 1'b1;
      pend_src_nxt    = live_src;
      pend_target_nxt = live_target;
    end
  end

  // Registered outputs and pending entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC & ADDR_MASK;
      pc_source   <= SRC_SEQ;
      fetch_req   <= 1'b0;
      pc_update   <= 1'b0;
      flush       <= 1'b0;
      pend_valid  <= 1'b0;
      pend_src    <= SRC_SEQ;
      pend_target <= '0;
    end else begin
      fetch_req   <= fetch_req_nxt;
      pc_update   <= do_update;
      flush       <= do_update && (src_nxt != SRC_SEQ);
      pend_valid  <= pend_valid_nxt;
      pend_src    <= pend_src_nxt;
      pend_target <= pend_target_nxt;
      if (do_update) begin
        pc        <= pc_nxt;
        pc_source <= src_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-computed expectations,
// plus a hand-written asynchronous reset sequence.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        fetch_ack;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_source;
  logic        pc_update;
  logic        flush;

  int checks;
  int failures;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .fetch_ack     (fetch_ack),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_source     (pc_source),
    .pc_update     (pc_update),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ack;
    logic [2:0]  rd;   // {jr, jump, branch_taken}
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic [1:0]  e_src;
    logic        e_req;
    logic        e_upd;
    logic        e_fl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic st, input logic ack, input logic [2:0] rd,
                              input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt,
                              input logic [31:0] e_pc, input logic [1:0] e_src,
                              input logic e_req, input logic e_upd, input logic e_fl);
    vec_t v;
    v.st = st; v.ack = ack; v.rd = rd; v.bt = bt; v.jt = jt; v.jrt = jrt;
    v.e_pc = e_pc; v.e_src = e_src; v.e_req = e_req; v.e_upd = e_upd; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [1:0] e_src,
                         input logic e_req, input logic e_upd, input logic e_fl);
    chk({tag, ".pc"},         pc,                 e_pc);
    chk({tag, ".fetch_addr"}, fetch_addr,         e_pc);
    chk({tag, ".pc_plus4"},   pc_plus4,           e_pc + 32'd4);
    chk({tag, ".pc_source"},  32'(pc_source),     32'(e_src));
    chk({tag, ".fetch_req"},  32'(fetch_req),     32'(e_req));
    chk({tag, ".pc_update"},  32'(pc_update),     32'(e_upd));
    chk({tag, ".flush"},      32'(flush),         32'(e_fl));
  endtask

  task automatic drive(input logic st, input logic ack, input logic [2:0] rd,
                       input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
    stall = st; fetch_ack = ack;
    jr = rd[2]; jump = rd[1]; branch_taken = rd[0];
    branch_target = bt; jump_target = jt; jr_target = jrt;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);

    // {stall, ack, {jr,jump,br}, bt, jt, jrt} -> {pc, src, req, upd, flush} after the edge
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0000, 2'b00, 1, 0, 0)); // BOOT -> REQ
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0004, 2'b00, 1, 1, 0));
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0008, 2'b00, 1, 1, 0));
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_000C, 2'b00, 1, 1, 0));
    vq.push_back(mk(0, 0, 3'b001, 32'h100, 0, 0, 32'h0000_000C, 2'b00, 1, 0, 0)); // branch while waiting
    vq.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0000_000C, 2'b00, 1, 0, 0));
    vq.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0000_000C, 2'b00, 1, 0, 0));
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0100, 2'b01, 1, 1, 1)); // pending applied
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0104, 2'b00, 1, 1, 0));
    vq.push_back(mk(0, 1, 3'b111, 32'h100, 32'h200, 32'h300, 32'h0000_0300, 2'b11, 1, 1, 1)); // priority
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0304, 2'b00, 1, 1, 0));
    vq.push_back(mk(1, 1, 3'b000, 0, 0, 0, 32'h0000_0304, 2'b00, 0, 0, 0)); // ack+stall -> HOLD
    vq.push_back(mk(1, 1, 3'b010, 0, 32'h80, 0, 32'h0000_0304, 2'b00, 0, 0, 0)); // jump pended
    vq.push_back(mk(1, 1, 3'b000, 0, 0, 0, 32'h0000_0304, 2'b00, 0, 0, 0));
    vq.push_back(mk(1, 1, 3'b000, 0, 0, 0, 32'h0000_0304, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0080, 2'b10, 1, 1, 1)); // stall released
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0084, 2'b00, 1, 1, 0));
    vq.push_back(mk(0, 1, 3'b100, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'b11, 1, 1, 1));
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0000, 2'b00, 1, 1, 0)); // wrap
    vq.push_back(mk(0, 1, 3'b001, 32'h103, 0, 0, 32'h0000_0100, 2'b01, 1, 1, 1)); // low bits dropped
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0104, 2'b00, 1, 1, 0));
    vq.push_back(mk(0, 0, 3'b001, 32'h200, 0, 0, 32'h0000_0104, 2'b00, 1, 0, 0));
    vq.push_back(mk(0, 0, 3'b010, 0, 32'h400, 0, 32'h0000_0104, 2'b00, 1, 0, 0)); // newest pends
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0400, 2'b10, 1, 1, 1));
    vq.push_back(mk(0, 0, 3'b100, 0, 0, 32'h500, 32'h0000_0400, 2'b10, 1, 0, 0));
    vq.push_back(mk(0, 1, 3'b001, 32'h600, 0, 0, 32'h0000_0600, 2'b01, 1, 1, 1)); // live beats pending
    vq.push_back(mk(0, 1, 3'b000, 0, 0, 0, 32'h0000_0604, 2'b00, 1, 1, 0)); // pending cleared

    // Reset state
    @(posedge clk); #1;
    chk_all("reset", 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].ack, vq[i].rd, vq[i].bt, vq[i].jt, vq[i].jrt);
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), vq[i].e_pc, vq[i].e_src, vq[i].e_req, vq[i].e_upd, vq[i].e_fl);
    end

    // Reset mid-wait with a pending redirect
    drive(1'b0, 1'b0, 3'b001, 32'h700, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk_all("rst_wait", 32'h0000_0604, 2'b00, 1'b1, 1'b0, 1'b0);
    #2;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_held", 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_boot", 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_seq1", 32'h4, 2'b00, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_seq2", 32'h8, 2'b00, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side sequencer that owns the program counter and drives the 2-bit `PCSource` select of the 4:1 next-PC mux (00 = PC+4, 01 = branch, 10 = jump, 11 = jr). It issues instruction fetches over a req/ack handshake with instruction memory. It absorbs redirects (branch, jump, jr) that arrive while a fetch is outstanding or the pipeline is stalled, and applies them at the next PC update. It sits between the control unit/branch logic and the instruction memory port.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC. No fetch is issued while high.
- `branch_taken`  in  1  branch redirect request.
- `branch_target`  in  32  branch target address.
- `jump`  in  1  J/JAL redirect request.
- `jump_target`  in  32  jump target address.
- `jr`  in  1  JR redirect request.
- `jr_target`  in  32  register target address.
- `fetch_ack`  in  1  instruction memory accepted/returned the fetch at `fetch_addr`.
- `fetch_req`  out  1  fetch request.
- `fetch_addr`  out  32  fetch address; always equals `pc`.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4`, combinational.
- `pc_source`  out  2  select code that produced the current `pc`.
- `pc_update`  out  1  one-cycle pulse on the cycle after `pc` changes.
- `flush`  out  1  one-cycle pulse when the PC update was a redirect (`pc_source != 00`).

## Operation
- States:
  - BOOT: first cycle after reset release; `fetch_req=0`.
  - REQ: `fetch_req=1`.
  - HOLD: stalled; `fetch_req=0`.
- BOOT -> REQ unconditionally.
- REQ:
  - `fetch_ack && !stall`: perform an update and stay in REQ.
  - `fetch_ack && stall`: go to HOLD; PC is not changed.
  - `!fetch_ack`: stay in REQ; `fetch_addr` is held stable.
- HOLD:
  - `!stall`: perform an update and go to REQ.
  - Otherwise stay in HOLD.
- Live redirect: any of `jr`, `jump`, `branch_taken` high in the current cycle. Priority is jr > jump > branch.
- Pending redirect (`pend_valid`, `pend_src`, `pend_target`):
  - Captured when a live redirect occurs in a cycle with no update.
  - A later live redirect overwrites it; the newest wins.
  - Cleared on an update.
- Next-PC selection at an update:
  - First choice: the live redirect.
  - Otherwise: the pending redirect.
  - Otherwise: `pc_plus4` with source 00.
- An update registers `pc`, `pc_source`, `pc_update=1`, and `flush=(source!=00)` on the clock edge.
- Width and address rules:
  - All arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - Target bits [1:0] are ignored; `pc[1:0]` is always 00.
  - `RESET_PC[1:0]` must be 00.

## Timing
- Reset values, forced immediately while `rst_n=0` regardless of clock:
  - `pc = RESET_PC`, `pc_source = 00`.
  - `fetch_req = 0`, `pc_update = 0`, `flush = 0`.
  - `pend_valid = 0`, state = BOOT.
- First `fetch_req` rises on the 1st rising edge after `rst_n` deasserts.
- Handshake: while `fetch_req=1 && !fetch_ack`, `fetch_addr` is held stable. A redirect arriving in this window does not alter the address; it is pended.
- Single-cycle fetch: with `fetch_ack` held high and `stall` low, `pc` advances every cycle. Throughput is 1 update/cycle, and a redirect reaches `pc` 1 edge after it is asserted.
- Redirect in the same cycle as ack: applied at that edge; no pending entry is created.
- `stall` and redirect asserted together:
  - The redirect is pended.
  - It is applied on the first edge after `stall` falls, even if the redirect input is low by then.
- `pc_update` and `flush` are high for exactly one cycle per update and never high in BOOT/HOLD entry cycles without an update.
- Reset asserted mid-fetch or in HOLD: state and the pending entry are discarded; the sequence restarts at BOOT.

## Test plan
- Reset, `fetch_ack=1` held, no redirects -> `pc` reads 0, 0 (BOOT), 4, 8, 12 on successive edges. `pc_source=00`, `flush=0`, `fetch_req=1` from cycle 1.
- `fetch_ack` low for 3 cycles with `branch_taken=1`, `branch_target=0x100` pulsed in the 1st wait cycle -> `fetch_addr` held at the old PC. On the ack edge `pc=0x100`, `pc_source=01`, `flush=1` for one cycle.
- `jr`, `jump`, `branch_taken` all high, targets 0x300/0x200/0x100, with ack -> `pc=0x300`, `pc_source=11`.
- `stall=1` for 4 cycles, with `jump` (target 0x80) pulsed in cycle 2 -> `pc` frozen and `fetch_req=0`. After stall drops: `pc=0x80`, `pc_source=10`, `flush=1`, then `0x84` next.
- `pc=0xFFFFFFFC`, ack -> `pc=0x00000000`, `pc_source=00`. `branch_target=0x103` -> `pc=0x100`.
- `rst_n` pulsed low mid-wait with a pending redirect -> outputs reset asynchronously. After release, fetch restarts at `RESET_PC` and the pending target is never applied.
